// File: rtl/store_buffer_pkg.sv
// Shared defaults, word-address slicing and entry layout for the store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // Address bits below WORD_LSB select a byte within a word and never take part in matching.
  localparam int WORD_LSB = 2;

  function automatic int word_w(input int addr_w);
    return addr_w - WORD_LSB;
  endfunction

  // An entry is stored as {addr, data}, with the address in the upper bits.
  function automatic int entry_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-first word-address match over the occupied slots of the store buffer.
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int WA_W  = 30
) (
  input  logic [WA_W-1:0]          entry_waddr [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH):0]   count,
  input  logic [WA_W-1:0]          key,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot_s;

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    hit    = 1'b0;
    idx    = head;
    slot_s = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = head + PTR_W'(i);
      if (((PTR_W + 1)'(i) < count) && (entry_waddr[slot_s] == key)) begin
        hit = 1'b1;
        idx = slot_s;
      end else begin
        hit = hit;
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the CPU memory port and word-addressed memory.
// STORE_BUF_FWD_EN enables load forwarding; without it loads wait for the buffer to empty.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              buf_empty,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = entry_w(ADDR_W, DATA_W);

  logic [ENT_W-1:0]  entry_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic              rd_valid_r;

  logic              full_s;
  logic              nonempty_s;
  logic              stall_s;
  logic              rd_ok_s;
  logic              push_s;
  logic              drain_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign nonempty_s  = (count_r != {CNT_W{1'b0}});
  assign head_addr_s = entry_r[head_r][ENT_W-1 -: ADDR_W];
  assign head_data_s = entry_r[head_r][DATA_W-1:0];

  // Stall, accept and drain decisions for the current cycle.
  always_comb begin
    stall_s = full_s;
`ifdef STORE_BUF_FWD_EN
    stall_s = full_s;
`else
    if (cpu_rd && nonempty_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = full_s;
    end
`endif
    // A read stalled by a full buffer lets the drain run, otherwise a held read could never retire.
    rd_ok_s = cpu_rd && !stall_s;
    push_s  = cpu_wr && !stall_s;
    drain_s = nonempty_s && !rd_ok_s;
  end

  // Entry storage needs no reset: only slots between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      entry_r[tail_r] <= {cpu_addr, cpu_wdata};
    end
  end

  // Circular pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign cpu_stall = stall_s;
  assign buf_empty = !nonempty_s;
  assign mem_wr    = drain_s;
  assign mem_addr  = drain_s ? head_addr_s : cpu_addr;
  assign mem_wdata = head_data_s;

`ifdef STORE_BUF_FWD_EN
  localparam int WA_W = word_w(ADDR_W);

  logic [WA_W-1:0]   entry_waddr_s [DEPTH];
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              fwd_hit_r;
  logic [DATA_W-1:0] fwd_data_r;

  // Word-address view of every slot for the match search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_waddr_s[i] = entry_r[i][ENT_W-1 -: WA_W];
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W)
  ) u_fwd_match (
    .entry_waddr (entry_waddr_s),
    .head        (head_r),
    .count       (count_r),
    .key         (cpu_addr[ADDR_W-1:WORD_LSB]),
    .hit         (hit_s),
    .idx         (hit_idx_s)
  );

  // Capture the forward decision alongside the memory read it replaces.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= rd_ok_s;
      fwd_hit_r  <= rd_ok_s && hit_s;
      if (rd_ok_s && hit_s) begin
        fwd_data_r <= entry_r[hit_idx_s][DATA_W-1:0];
      end else begin
        fwd_data_r <= fwd_data_r;
      end
    end
  end

  assign cpu_rdata = !rd_valid_r ? {DATA_W{1'b0}} :
                     (fwd_hit_r ? fwd_data_r : mem_rdata);
`else
  // Track which cycle carries a valid memory read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_ok_s;
    end
  end

  assign cpu_rdata = rd_valid_r ? mem_rdata : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, corner sequences, random vs program-order model.
module tb_store_buffer;

  localparam int DEPTH = 4;
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        buf_empty;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (addr),
    .cpu_wdata (wdata),
    .cpu_wr    (wr),
    .cpu_rd    (rd),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .buf_empty (buf_empty),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  // Word-addressed memory, 256 words, 1-cycle read latency; unwritten words read C000_0000|index.
  logic [31:0]  memarr [256];
  logic [255:0] written;
  logic         mem_clr;

  function automatic logic [31:0] mem_val(input int i);
    return written[i] ? memarr[i] : (32'hC000_0000 | 32'(i));
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (mem_wr) begin
      memarr[mem_addr[9:2]]  <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
    mem_rdata <= mem_val(int'(mem_addr[9:2]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wr = w; rd = r; addr = a; wdata = d;
  endtask

  task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    drive(w, r, a, d);
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    drive(1'b1, 1'b0, a, d);
    @(negedge clk);
    while (cpu_stall && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("store_accept_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp, output int stalls);
    int n;
    n = 0;
    drive(1'b0, 1'b1, a, 32'h0);
    @(negedge clk);
    while (cpu_stall && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({name, "_stall"}, 32'(cpu_stall), 32'h0);
    check({name, "_mem_wr"}, 32'(mem_wr), 32'h0);
    check({name, "_mem_addr"}, mem_addr, a);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, a, 32'h0);
    @(negedge clk);
    check(name, cpu_rdata, exp);
    @(posedge clk); #1;
    stalls = n;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_mwr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic        exp_empty;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  vec_t        tbl [10];
  ent_t        q [$];
  logic [31:0] arch [256];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   nst;
    int   wcount;
    logic hold, rd_pend, rd_ok, wr_ok, drain, exp_stall;
    logic r_wr, r_rd;
    logic [31:0] r_addr, r_data, rd_exp;

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1; mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check("reset_empty", 32'(buf_empty), 32'h1);
    check("reset_stall", 32'(cpu_stall), 32'h0);
    check("reset_mem_wr", 32'(mem_wr), 32'h0);
    check("reset_rdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;

    tbl[0] = '{1'b0, 1'b1, 32'h00, 32'h00, 1'b0, 32'h00, 32'h00, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 32'h00, 32'h00, 1'b1, 32'hC000_0000};
    tbl[2] = '{1'b1, 1'b0, 32'h10, 32'hA0, 1'b0, 32'h10, 32'h00, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h14, 32'hA1, 1'b1, 32'h10, 32'hA0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 32'h18, 32'hA2, 1'b1, 32'h14, 32'hA1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h1C, 32'hA3, 1'b1, 32'h18, 32'hA2, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b1, 32'h1C, 32'hA3, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 32'h40, 32'h00, 1'b0, 32'h40, 32'h00, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 1'b1, 32'h14, 32'h00, 1'b0, 32'h14, 32'h00, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 1'b0, 32'h00, 32'h00, 1'b0, 32'h00, 32'h00, 1'b1, 32'hA1};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata);
      @(negedge clk);
      check($sformatf("tbl%0d_stall", i), 32'(cpu_stall), 32'h0);
      check($sformatf("tbl%0d_mem_wr", i), 32'(mem_wr), 32'(tbl[i].exp_mwr));
      check($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].exp_maddr);
      if (tbl[i].exp_mwr) check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].exp_mwdata);
      check($sformatf("tbl%0d_empty", i), 32'(buf_empty), 32'(tbl[i].exp_empty));
      check($sformatf("tbl%0d_rdata", i), cpu_rdata, tbl[i].exp_rdata);
      @(posedge clk); #1;
    end

    // Two stores to one word followed at once by a load of it.
    do_store(32'h20, 32'h11);
    do_store(32'h20, 32'h22);
    do_read("newest_store", 32'h20, 32'h22, nst);
    if (FWD) check("stale_mem_during_fwd", mem_val(8), 32'h11);
    else     check("nofwd_rd_stalled", 32'(nst >= 1), 32'h1);

    // Same word, different byte offset; then a word never stored.
    do_store(32'h24, 32'h33);
    do_read("same_word", 32'h26, 32'h33, nst);
    do_read("miss", 32'h28, 32'hC000_000A, nst);

    do_store(32'h30, 32'h44);
    do_read("rd_after_store", 32'h30, 32'h44, nst);
    if (!FWD) check("nofwd_stall_until_empty", 32'(nst >= 1), 32'h1);

    // Partially filled buffer discarded by reset.
    cyc(1'b1, 1'b0, 32'h50, 32'hD0);
    cyc(1'b1, 1'b1, 32'h54, 32'hD1);
    cyc(1'b1, 1'b1, 32'h58, 32'hD2);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("pre_reset_nonempty", 32'(buf_empty), 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_empty", 32'(buf_empty), 32'h1);
    check("rst_mid_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mid_stall", 32'(cpu_stall), 32'h0);
    check("rst_mid_rdata", cpu_rdata, 32'h0);
    wcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_wr) wcount++;
    end
    check("no_writes_after_reset", 32'(wcount), 32'h0);
    if (FWD) check("discarded_store_absent", mem_val(22), 32'hC000_0016);
    @(posedge clk); #1;

    // Random traffic checked against a program-order memory image and a FIFO of pending stores.
    for (int i = 0; i < 256; i++) arch[i] = mem_val(i);
    hold = 1'b0; rd_pend = 1'b0; rd_exp = 32'h0;
    r_wr = 1'b0; r_rd = 1'b0; r_addr = 32'h0; r_data = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      if (!hold) begin
        r_wr   = ($urandom_range(0, 99) < 50);
        r_rd   = ($urandom_range(0, 99) < 40);
        r_addr = 32'h200 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
        r_data = $urandom;
      end
      drive(r_wr, r_rd, r_addr, r_data);
      @(negedge clk);
      exp_stall = (q.size() == DEPTH) || (!FWD && r_rd && q.size() != 0);
      check("rnd_stall", 32'(cpu_stall), 32'(exp_stall));
      check("rnd_empty", 32'(buf_empty), 32'(q.size() == 0));
      check("rnd_rdata", cpu_rdata, rd_pend ? rd_exp : 32'h0);
      rd_ok = r_rd && !exp_stall;
      wr_ok = r_wr && !exp_stall;
      drain = (q.size() != 0) && !rd_ok;
      check("rnd_mem_wr", 32'(mem_wr), 32'(drain));
      if (drain) begin
        check("rnd_drain_addr", mem_addr, q[0].a);
        check("rnd_drain_data", mem_wdata, q[0].d);
        void'(q.pop_front());
      end else begin
        check("rnd_mem_addr", mem_addr, r_addr);
      end
      rd_pend = rd_ok;
      if (rd_ok) rd_exp = arch[r_addr[9:2]];
      if (wr_ok) begin
        q.push_back('{r_addr, r_data});
        arch[r_addr[9:2]] = r_data;
      end
      hold = exp_stall && (r_wr || r_rd);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
